// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory op encodings, FSM states, op helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  // Halfword ops need an even address, word ops a 4-byte aligned one.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = lo[0];
      MEM_LW, MEM_SW:          bad = |lo;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Load formatter: picks the addressed byte/half lane of a read word and extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection, then sign/zero extension by op.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (op)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'h000000, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'h0000, half_sel};
      MEM_LW:  data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores over a req/ack data-memory port, passes other ops through.
// Latency: 0 cycles for non-memory ops; memory ops take 2 + (ack wait) stall cycles.
// Backpressure: mem_stall holds upstream from issue until the DONE cycle; writeback is masked while stalled.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_alu_result_low,
  input  logic [31:0] ex_store_data,
  input  logic        ex_reg_wr,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_to_pc,
  output logic        mem_stall,
  output logic        mem_addr_err,
  output logic [31:0] mem_mem_data,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_alu_result_low,
  output logic        mem_reg_wr,
  output logic [4:0]  mem_waddr,
  output logic        mem_to_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  state_t      state_q, state_nxt;
  logic        mem_op_vld;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] load_buf_q;
  logic [31:0] fmt_data;

  // An invalid slot is a bubble regardless of its op field.
  always_comb begin
    mem_op_vld = ex_valid && op_is_mem(ex_mem_op);
    misaligned = mem_op_vld && op_misaligned(ex_mem_op, ex_alu_result[1:0]);
    start      = (state_q == ST_IDLE) && mem_op_vld && !misaligned;
  end

  // Store lane logic: byte enables and lane-replicated write data.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'h0000_0000;
    case (ex_mem_op)
      MEM_SB: begin
        be_nxt    = 4'b0001 << ex_alu_result[1:0];
        wdata_nxt = {4{ex_store_data[7:0]}};
      end
      MEM_SH: begin
        be_nxt    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{ex_store_data[15:0]}};
      end
      MEM_SW: begin
        be_nxt    = 4'b1111;
        wdata_nxt = ex_store_data;
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = 32'h0000_0000;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state: one IDLE issue cycle, BUSY until ack, one DONE cycle for the result.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
      ST_BUSY: if (dmem_ack) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: stall while issuing/waiting, mask writeback so MEM/WB only sees bubbles.
  always_comb begin
    mem_stall    = 1'b0;
    mem_addr_err = 1'b0;
    mem_mem_data = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        mem_stall    = start;
        mem_addr_err = misaligned;
      end
      ST_BUSY: mem_stall = 1'b1;
      ST_DONE: mem_mem_data = load_buf_q;
      default: ;
    endcase
    mem_reg_wr         = ex_reg_wr && !mem_stall && !mem_addr_err;
    mem_to_pc          = ex_to_pc && !mem_stall;
    mem_alu_result     = ex_alu_result;
    mem_alu_result_low = ex_alu_result_low;
    mem_waddr          = ex_waddr;
  end

  // Handshake registers and load buffer: latch the request at issue, capture data at ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      op_q       <= MEM_NONE;
      off_q      <= 2'b00;
      load_buf_q <= 32'h0000_0000;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= op_is_store(ex_mem_op);
      dmem_addr  <= {ex_alu_result[31:2], 2'b00};
      dmem_be    <= be_nxt;
      dmem_wdata <= wdata_nxt;
      op_q       <= ex_mem_op;
      off_q      <= ex_alu_result[1:0];
    end else if ((state_q == ST_BUSY) && dmem_ack) begin
      dmem_req   <= 1'b0;
      load_buf_q <= op_is_load(op_q) ? fmt_data : 32'h0000_0000;
    end
  end

  load_formatter u_load_formatter (
    .rdata   (dmem_rdata),
    .addr_lo (off_q),
    .op      (op_q),
    .data    (fmt_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random instruction stream against a byte-addressed reference memory.
// Latency: drives one EX/MEM slot at a time, holding it while mem_stall is high.
// Backpressure: a memory responder acks after a random or forced number of wait cycles.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_alu_result_low;
  logic [31:0] ex_store_data;
  logic        ex_reg_wr;
  logic [4:0]  ex_waddr;
  logic        ex_to_pc;
  logic        mem_stall;
  logic        mem_addr_err;
  logic [31:0] mem_mem_data;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_alu_result_low;
  logic        mem_reg_wr;
  logic [4:0]  mem_waddr;
  logic        mem_to_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_alu_result_low(ex_alu_result_low),
    .ex_store_data(ex_store_data), .ex_reg_wr(ex_reg_wr), .ex_waddr(ex_waddr),
    .ex_to_pc(ex_to_pc), .mem_stall(mem_stall), .mem_addr_err(mem_addr_err),
    .mem_mem_data(mem_mem_data), .mem_alu_result(mem_alu_result),
    .mem_alu_result_low(mem_alu_result_low), .mem_reg_wr(mem_reg_wr),
    .mem_waddr(mem_waddr), .mem_to_pc(mem_to_pc), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] rsp_mem [0:1023];

  int          force_lat   = -1;
  int          cur_lat     = -100;
  bit          spurious_en = 1'b1;
  logic [31:0] exp_addr;
  logic        exp_we;
  logic [3:0]  exp_be;
  bit          exp_be_chk;
  logic [31:0] exp_wdata;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;
  logic [31:0] last_data;
  int          last_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic void set_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    w = (w & ~(32'hFF << (8 * a[1:0]))) | (32'(b) << (8 * a[1:0]));
    ref_mem[a[11:2]] = w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    v  = 32'h0;
    sz = op_size(op);
    for (int k = 0; k < sz; k++) v = v | (32'(byte_at(a + 32'(k))) << (8 * k));
    if ((op == MEM_LB || op == MEM_LH) && v[8*sz-1])
      v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  function automatic void ref_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < op_size(op); k++) set_byte(a + 32'(k), 8'(d >> (8 * k)));
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int          rsp_wait;
    int          rsp_lat;
    bit          rsp_busy;
    logic [31:0] w;
    rsp_busy   = 1'b0;
    rsp_wait   = 0;
    rsp_lat    = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_busy = 1'b0;
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        if (!rsp_busy) begin
          rsp_busy = 1'b1;
          rsp_wait = 0;
          rsp_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          cur_lat  = rsp_lat;
          snap_addr = dmem_addr; snap_we = dmem_we; snap_be = dmem_be; snap_wdata = dmem_wdata;
          chk("req_addr", dmem_addr, {exp_addr[31:2], 2'b00});
          chk("req_we", 32'(dmem_we), 32'(exp_we));
          if (exp_be_chk) chk("req_be", 32'(dmem_be), 32'(exp_be));
          if (exp_we) chk("req_wdata", dmem_wdata, exp_wdata);
        end else begin
          chk("hold_addr", dmem_addr, snap_addr);
          chk("hold_we", 32'(dmem_we), 32'(snap_we));
          chk("hold_be", 32'(dmem_be), 32'(snap_be));
          chk("hold_wdata", dmem_wdata, snap_wdata);
        end
        if (rsp_wait == rsp_lat) begin
          dmem_ack = 1'b1;
          rsp_busy = 1'b0;
          if (dmem_we) begin
            w = rsp_mem[dmem_addr[11:2]];
            for (int j = 0; j < 4; j++)
              if (dmem_be[j]) w[8*j +: 8] = dmem_wdata[8*j +: 8];
            rsp_mem[dmem_addr[11:2]] = w;
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = rsp_mem[dmem_addr[11:2]];
          end
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          rsp_wait++;
        end
      end else begin
        rsp_busy   = 1'b0;
        dmem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- one instruction through the stage ----------------
  task automatic run_instr(input bit valid, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] lowv, input bit reg_wr,
                           input logic [4:0] waddr, input bit to_pc);
    bit          access, mis;
    int          sz, stalls;
    logic [31:0] exp_data;
    sz       = op_size(op);
    access   = valid && (sz > 0);
    mis      = access && ((addr % sz) != 0);
    access   = access && !mis;
    exp_data = 32'h0;
    if (access && !is_store(op)) exp_data = ref_load(op, addr);
    if (access && is_store(op))  ref_store(op, addr, sdata);
    exp_addr   = addr;
    exp_we     = is_store(op);
    exp_be     = 4'b0000;
    exp_wdata  = 32'h0;
    exp_be_chk = is_store(op) || (sz == 4);
    for (int k = 0; k < sz; k++) exp_be = exp_be | 4'(1 << ((addr + 32'(k)) & 3));
    if (sz > 0)
      for (int j = 0; j < 4; j++) exp_wdata = exp_wdata | (32'(8'(sdata >> (8 * (j % sz)))) << (8 * j));
    cur_lat = -100;

    ex_valid = valid; ex_mem_op = op; ex_alu_result = addr; ex_alu_result_low = lowv;
    ex_store_data = sdata; ex_reg_wr = reg_wr; ex_waddr = waddr; ex_to_pc = to_pc;

    stalls = 0;
    @(negedge clk);
    while (mem_stall && stalls < 50) begin
      chk("stall_reg_wr", 32'(mem_reg_wr), 32'h0);
      chk("stall_to_pc", 32'(mem_to_pc), 32'h0);
      chk("stall_addr_err", 32'(mem_addr_err), 32'h0);
      stalls++;
      @(negedge clk);
    end
    if (mem_stall) chk("stall_timeout", 32'h1, 32'h0);
    chk("stall_cycles", 32'(stalls), access ? 32'(cur_lat + 2) : 32'h0);
    chk("addr_err", 32'(mem_addr_err), 32'(mis));
    chk("reg_wr", 32'(mem_reg_wr), 32'(reg_wr && !mis));
    chk("to_pc", 32'(mem_to_pc), 32'(to_pc));
    chk("alu_result", mem_alu_result, addr);
    chk("alu_result_low", mem_alu_result_low, lowv);
    chk("waddr", 32'(mem_waddr), 32'(waddr));
    chk("mem_data", mem_mem_data, exp_data);
    chk("req_idle", 32'(dmem_req), 32'h0);
    last_data   = mem_mem_data;
    last_stalls = stalls;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 32'h0);
    chk({tag, "_we"}, 32'(dmem_we), 32'h0);
    chk({tag, "_be"}, 32'(dmem_be), 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'h0);
    chk({tag, "_err"}, 32'(mem_addr_err), 32'h0);
    chk({tag, "_data"}, mem_mem_data, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int          sz;
    bit          v;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      rsp_mem[i] = ref_mem[i];
    end
    ref_mem[10'h040] = 32'hDEADBEEF; rsp_mem[10'h040] = 32'hDEADBEEF;
    ref_mem[10'h080] = 32'h80FF7F01; rsp_mem[10'h080] = 32'h80FF7F01;

    rst = 1'b1; ex_valid = 1'b0; ex_mem_op = MEM_NONE; ex_alu_result = 32'h0;
    ex_alu_result_low = 32'h0; ex_store_data = 32'h0; ex_reg_wr = 1'b0;
    ex_waddr = 5'd0; ex_to_pc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Pass-through ALU op.
    run_instr(1, MEM_NONE, 32'h12345678, 32'h0, 32'h0BADF00D, 1, 5'd5, 0);
    chk("add_lit_stalls", 32'(last_stalls), 32'd0);

    // LW with immediate ack.
    force_lat = 0;
    run_instr(1, MEM_LW, 32'h100, 32'h0, 32'h0, 1, 5'd7, 0);
    chk("lw_lit_data", last_data, 32'hDEADBEEF);
    chk("lw_lit_stalls", 32'(last_stalls), 32'd2);
    chk("lw_lit_addr", snap_addr, 32'h100);
    chk("lw_lit_be", 32'(snap_be), 32'hF);

    // Byte/half lane extension.
    force_lat = -1;
    run_instr(1, MEM_LB, 32'h203, 32'h0, 32'h0, 1, 5'd8, 0);
    chk("lb_lit_data", last_data, 32'hFFFFFF80);
    run_instr(1, MEM_LBU, 32'h203, 32'h0, 32'h0, 1, 5'd9, 0);
    chk("lbu_lit_data", last_data, 32'h00000080);
    run_instr(1, MEM_LH, 32'h202, 32'h0, 32'h0, 1, 5'd10, 0);
    chk("lh_lit_data", last_data, 32'hFFFF80FF);

    // SB with three wait cycles.
    force_lat = 3;
    run_instr(1, MEM_SB, 32'h301, 32'h000000AB, 32'h0, 0, 5'd0, 0);
    chk("sb_lit_be", 32'(snap_be), 32'h2);
    chk("sb_lit_wdata", snap_wdata, 32'hABABABAB);
    chk("sb_lit_stalls", 32'(last_stalls), 32'd5);
    force_lat = -1;

    // Misaligned LW is dropped.
    run_instr(1, MEM_LW, 32'h102, 32'h0, 32'h0, 1, 5'd3, 0);
    chk("mis_lit_stalls", 32'(last_stalls), 32'd0);

    // Reset in the middle of a pending access.
    force_lat = 100000; spurious_en = 1'b0;
    exp_addr = 32'h40; exp_we = 1'b0; exp_be = 4'hF; exp_be_chk = 1'b1; exp_wdata = 32'h0;
    ex_valid = 1'b1; ex_mem_op = MEM_LW; ex_alu_result = 32'h40; ex_reg_wr = 1'b1; ex_to_pc = 1'b0;
    @(negedge clk);
    chk("rstb_issue_stall", 32'(mem_stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstb_busy_req", 32'(dmem_req), 32'h1);
    chk("rstb_busy_stall", 32'(mem_stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0; ex_mem_op = MEM_NONE; ex_alu_result = 32'h0; ex_reg_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_busy");
    @(posedge clk); #1;
    force_lat = -1; spurious_en = 1'b1;

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 8));
      v  = ($urandom_range(0, 9) != 0);
      sz = op_size(op);
      if (sz == 0) begin
        a = $urandom;
        run_instr(v, op, a, $urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
      end else begin
        a = 32'($urandom_range(0, 4095));
        if ($urandom_range(0, 4) != 0) a = a & ~32'(sz - 1);
        run_instr(v, op, a, $urandom, $urandom, !is_store(op), 5'($urandom), 1'b0);
      end
    end

    // Stores must have landed in the same bytes the model wrote.
    for (int i = 0; i < 1024; i++)
      if (rsp_mem[i] !== ref_mem[i]) chk("final_mem", rsp_mem[i], ref_mem[i]);
    n_cmp++;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
